// File: rtl/mcp_data_launcher_pkg.sv
// mcp_data_launcher_pkg: state encoding and counter sizing shared by MCP launchers
package mcp_data_launcher_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } mcp_state_e;
  function automatic int mcp_cnt_width(input int a, input int b);
    int m;
    m = a > b ? a : b;
    return m <= 2 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/mcp_phase_counter.sv
// mcp_phase_counter: loadable down-counter that stops at zero and flags it
module mcp_phase_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (load) count <= load_value;
    else if (count != '0) count <= count - 1'b1;
  end
  assign zero = count == '0;
endmodule

// File: rtl/mcp_data_launcher.sv
// mcp_data_launcher: holds a word on a quasi-static bus with a hold/gap level valid for an MCP synchronizer
module mcp_data_launcher
  import mcp_data_launcher_pkg::*;
#(
  parameter int BUS_WIDTH   = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [BUS_WIDTH-1:0] in_data,
  output logic                 in_ready,
  output logic                 mcp_data_valid,
  output logic [BUS_WIDTH-1:0] mcp_data,
  output logic                 busy
);
  localparam int CW = mcp_cnt_width(HOLD_CYCLES, GAP_CYCLES);
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYCLES - 1);
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1) begin : g_bad_params
    $error("mcp_data_launcher: HOLD_CYCLES and GAP_CYCLES must be >= 1");
  end
  mcp_state_e    state, state_nxt;
  logic          fire, load, zero;
  logic [CW-1:0] load_value;
  assign in_ready = (state == IDLE) & ~reset;
  assign fire     = in_valid & in_ready;
  always_comb begin
    state_nxt  = state == IDLE ? (fire ? HOLD : IDLE) :
                 state == HOLD ? (zero ? GAP : HOLD) :
                 state == GAP  ? (zero ? IDLE : GAP) : IDLE;
    load       = (state == IDLE & fire) | (state == HOLD & zero);
    load_value = state == IDLE ? HOLD_LD : GAP_LD;
  end
  mcp_phase_counter #(.WIDTH(CW)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .zero      (zero)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      mcp_data_valid <= 1'b0;
      mcp_data       <= '0;
      busy           <= 1'b0;
    end else begin
      state          <= state_nxt;
      mcp_data_valid <= state_nxt == HOLD;
      busy           <= state_nxt != IDLE;
      if (fire) mcp_data <= in_data;
    end
  end
endmodule

// File: tb/tb_mcp_data_launcher.sv
// tb_mcp_data_launcher: table, directed and random checks against a cycle-position reference model
module tb_mcp_data_launcher;
  localparam int H = 4;
  localparam int G = 3;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, mcp_data_valid, busy;
  logic [7:0] mcp_data;
  int         tests = 0;
  int         fails = 0;
  int         pos = 0;
  logic [7:0] m_data = 8'h00;
  always #5 clk = ~clk;
  mcp_data_launcher #(.BUS_WIDTH(8), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .mcp_data_valid(mcp_data_valid),
    .mcp_data      (mcp_data),
    .busy          (busy)
  );
  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic       er;
  } vec_t;
  vec_t tbl[12];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask
  // pos = cycles since the last accepted word (0 = idle); a word occupies positions 1..H+G
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      pos = 0;
      m_data = 8'h00;
    end else if (pos == 0) begin
      if (in_valid) begin
        pos = 1;
        m_data = in_data;
      end
    end else pos = (pos == H + G) ? 0 : pos + 1;
    #1;
    chk("model_valid", mcp_data_valid, (pos >= 1 && pos <= H));
    chk("model_data", mcp_data, m_data);
    chk("model_busy", busy, (pos != 0));
    chk("model_ready", in_ready, (pos == 0 && !reset));
  endtask
  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    int low;
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 8'h33, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 8'h33, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 8'h33, 1'b1, 8'hA5, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 8'h33, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 8'h33, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 8'h33, 1'b0, 8'hA5, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h33, 1'b0, 8'hA5, 1'b0, 1'b1};
    for (int i = 0; i < 12; i++) begin
      reset = tbl[i].rst;
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      tick();
      chk($sformatf("tbl%0d_valid", i), mcp_data_valid, tbl[i].ev);
      chk($sformatf("tbl%0d_data", i), mcp_data, tbl[i].ed);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("tbl%0d_ready", i), in_ready, tbl[i].er);
    end
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h11;
    tick();
    in_data = 8'h22;
    low = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (!mcp_data_valid) low++;
      if (c < 8) chk("b2b_hold_11", mcp_data, 8'h11);
    end
    tick();
    chk("b2b_data_22", mcp_data, 8'h22);
    chk("b2b_valid_22", mcp_data_valid, 1'b1);
    chk("b2b_low_cycles", low, G + 1);
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h3C;
    tick();
    for (int c = 1; c <= 7; c++) begin
      in_data = c[0] ? 8'hFF : 8'h00;
      tick();
      chk("toggle_stable", mcp_data, 8'h3C);
    end
    in_data = 8'h99;
    tick();
    chk("toggle_next_word", mcp_data, 8'h99);
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("midreset_valid", mcp_data_valid, 1'b0);
    chk("midreset_data", mcp_data, 8'h00);
    chk("midreset_busy", busy, 1'b0);
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h77;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= H + G; c++) begin
      tick();
      chk("after_reset_valid", mcp_data_valid, (c < H));
    end
    chk("after_reset_data", mcp_data, 8'h77);
    chk("after_reset_ready", in_ready, 1'b1);
    for (int c = 0; c < 500; c++) begin
      reset = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      in_data = 8'($urandom);
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
